// File: rtl/fpu_issue_ctrl.sv
// Issue controller between a request stream and a fixed-latency FPU: request FIFO,
// credit-gated issue, valid-token pipeline matching the FPU latency, and a result buffer.
module fpu_issue_ctrl #(
  parameter int REQ_DEPTH   = 4,
  parameter int RSP_DEPTH   = 4,
  parameter int FPU_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  input  logic [2:0]  req_operation,
  output logic [31:0] Operand1,
  output logic [31:0] Operand2,
  output logic [2:0]  Operation,
  input  logic [31:0] FpuResult,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_operation
);

  localparam int QAW = $clog2(REQ_DEPTH);
  localparam int QCW = QAW + 1;
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int RCW = RAW + 1;
  localparam int IFW = $clog2(FPU_LATENCY + 1);
  localparam int SW  = 6;

  logic [31:0]    q_op1 [REQ_DEPTH];
  logic [31:0]    q_op2 [REQ_DEPTH];
  logic [2:0]     q_opc [REQ_DEPTH];
  logic [QAW-1:0] q_wr, q_rd;
  logic [QCW-1:0] q_cnt;

  logic [31:0]    r_res [RSP_DEPTH];
  logic [2:0]     r_opc [RSP_DEPTH];
  logic [RAW-1:0] r_wr, r_rd;
  logic [RCW-1:0] r_cnt;

  logic           tok_vld_p [FPU_LATENCY];
  logic [2:0]     tok_op_p  [FPU_LATENCY];
  logic [IFW-1:0] inflight;

  logic accept, issue, capture, pop_rsp;

  assign req_ready = ~RST & (q_cnt != QCW'(REQ_DEPTH));
  assign accept    = req_valid & req_ready;
  // A slot in the result buffer is reserved for every token still in the pipe.
  assign issue     = ~RST & (q_cnt != '0) &
                     ((SW'(inflight) + SW'(r_cnt)) < SW'(RSP_DEPTH));
  assign capture   = tok_vld_p[FPU_LATENCY-1];
  assign rsp_valid = (r_cnt != '0);
  assign pop_rsp   = rsp_valid & rsp_ready;

  assign rsp_result    = rsp_valid ? r_res[r_rd] : '0;
  assign rsp_operation = rsp_valid ? r_opc[r_rd] : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_wr      <= '0;
      q_rd      <= '0;
      q_cnt     <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      inflight  <= '0;
      Operand1  <= '0;
      Operand2  <= '0;
      Operation <= '0;
      for (int i = 0; i < FPU_LATENCY; i++) tok_vld_p[i] <= 1'b0;
    end else begin
      // request FIFO -> FPU operand registers
      if (accept) q_wr <= q_wr + QAW'(1);
      if (issue) begin
        q_rd      <= q_rd + QAW'(1);
        Operand1  <= q_op1[q_rd];
        Operand2  <= q_op2[q_rd];
        Operation <= q_opc[q_rd];
      end
      q_cnt <= q_cnt + QCW'(accept) - QCW'(issue);
      // token pipeline tracking the FPU latency
      tok_vld_p[0] <= issue;
      for (int i = 1; i < FPU_LATENCY; i++) tok_vld_p[i] <= tok_vld_p[i-1];
      inflight <= inflight + IFW'(issue) - IFW'(capture);
      // result buffer
      if (capture) r_wr <= r_wr + RAW'(1);
      if (pop_rsp) r_rd <= r_rd + RAW'(1);
      r_cnt <= r_cnt + RCW'(capture) - RCW'(pop_rsp);
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      q_op1[q_wr] <= req_op1;
      q_op2[q_wr] <= req_op2;
      q_opc[q_wr] <= req_operation;
    end
    tok_op_p[0] <= q_opc[q_rd];
    for (int i = 1; i < FPU_LATENCY; i++) tok_op_p[i] <= tok_op_p[i-1];
    if (capture) begin
      r_res[r_wr] <= FpuResult;
      r_opc[r_wr] <= tok_op_p[FPU_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: stand-in two-cycle FPU, queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fpu_issue_ctrl;
  localparam int REQ_DEPTH   = 4;
  localparam int RSP_DEPTH   = 4;
  localparam int FPU_LATENCY = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready;
  logic [31:0] req_op1, req_op2;
  logic [2:0]  req_operation;
  logic [31:0] Operand1, Operand2;
  logic [2:0]  Operation;
  logic [31:0] FpuResult = '0;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_operation;

  fpu_issue_ctrl #(.REQ_DEPTH(REQ_DEPTH), .RSP_DEPTH(RSP_DEPTH), .FPU_LATENCY(FPU_LATENCY)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_operation(req_operation),
    .Operand1(Operand1), .Operand2(Operand2), .Operation(Operation),
    .FpuResult(FpuResult), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_operation(rsp_operation)
  );

  always #5 CLK = ~CLK;

  // Stand-in FPU: exact sum for the known add vector, a cheap mix otherwise.
  function automatic logic [31:0] fpu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (op == 3'd0 && a == 32'h46BFCA0A && b == 32'h424BEB85) return 32'h46C03000;
    return (a ^ {b[15:0], b[31:16]}) + {29'd0, op} * 32'h9E3779B9;
  endfunction

  // One register stage after the operand registers gives a latency of two edges.
  always @(posedge CLK) FpuResult <= fpu_f(Operand1, Operand2, Operation);

  typedef struct packed { logic [31:0] a; logic [31:0] b; logic [2:0] op; } req_t;
  typedef struct { req_t r; int age; } fl_t;
  typedef struct packed { logic [31:0] res; logic [2:0] op; } rsp_t;

  req_t  m_reqq[$];
  fl_t   m_infl[$];
  rsp_t  m_rspq[$];
  logic [31:0] m_op1 = '0, m_op2 = '0;
  logic [2:0]  m_opc = '0;
  int    m_iss_total = 0;
  int    cyc = 0;
  req_t  mr;
  fl_t   mf;
  bit    m_acc, m_iss, m_pop, m_cap;

  int errors = 0, checks = 0;
  bit chk_en = 0;
  int hs_cnt = 0, hs_first = 0, hs_last = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: queues of waiting, in-flight and finished operations.
  always @(posedge CLK) begin
    if (RST) begin
      m_reqq.delete();
      m_infl.delete();
      m_rspq.delete();
      m_op1 = '0;
      m_op2 = '0;
      m_opc = '0;
    end else begin
      m_acc = req_valid && (m_reqq.size() < REQ_DEPTH);
      m_iss = (m_reqq.size() > 0) && (m_infl.size() + m_rspq.size() < RSP_DEPTH);
      m_pop = (m_rspq.size() > 0) && rsp_ready;
      m_cap = (m_infl.size() > 0) && (m_infl[0].age == FPU_LATENCY - 1);
      if (m_pop) void'(m_rspq.pop_front());
      if (m_cap) begin
        mf = m_infl.pop_front();
        m_rspq.push_back('{res: fpu_f(mf.r.a, mf.r.b, mf.r.op), op: mf.r.op});
      end
      foreach (m_infl[i]) m_infl[i].age++;
      if (m_iss) begin
        mr = m_reqq.pop_front();
        m_op1 = mr.a;
        m_op2 = mr.b;
        m_opc = mr.op;
        m_infl.push_back('{r: mr, age: 0});
        m_iss_total++;
      end
      if (m_acc) m_reqq.push_back('{a: req_op1, b: req_op2, op: req_operation});
    end
    cyc++;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(!RST && (m_reqq.size() < REQ_DEPTH)));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rspq.size() > 0));
      chk("rsp_result", rsp_result, (m_rspq.size() > 0) ? m_rspq[0].res : 32'd0);
      chk("rsp_operation", 32'(rsp_operation), (m_rspq.size() > 0) ? 32'(m_rspq[0].op) : 32'd0);
      chk("Operand1", Operand1, m_op1);
      chk("Operand2", Operand2, m_op2);
      chk("Operation", 32'(Operation), 32'(m_opc));
      if (!RST && rsp_valid && rsp_ready) begin
        if (hs_cnt == 0) hs_first = cyc;
        hs_last = cyc;
        hs_cnt++;
      end
    end
  end

  task automatic new_req();
    req_op1       = $urandom;
    req_op2       = $urandom;
    req_operation = 3'($urandom_range(7));
  endtask

  // mode 0: rsp_ready=1, mode 1: rsp_ready=0, mode 2: random valid and ready
  task automatic run_reqs(input int n, input int mode, input int maxcyc, output int sent);
    int c;
    logic hs;
    sent = 0;
    c = 0;
    new_req();
    while (sent < n && c < maxcyc) begin
      req_valid = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
      rsp_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(1));
      @(negedge CLK);
      hs = req_valid && req_ready;
      @(posedge CLK);
      #1;
      if (hs) begin
        sent++;
        new_req();
      end
      c++;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain(input int maxcyc);
    int c;
    c = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while ((m_reqq.size() + m_infl.size() + m_rspq.size()) != 0 && c < maxcyc) begin
      @(posedge CLK);
      #1;
      c++;
    end
    chk("drain_complete", 32'(c < maxcyc), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, s2, iss0;
    bit found;
    RST = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_op1 = '0;
    req_op2 = '0;
    req_operation = '0;

    // reset values
    @(posedge CLK);
    #1 chk_en = 1'b1;
    @(negedge CLK);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_Operand1", Operand1, 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("post_reset_req_ready", 32'(req_ready), 32'd1);
    @(posedge CLK);
    #1;

    // single add: operands one edge after accept, result three edges after accept
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_op1 = 32'h46BFCA0A;
    req_op2 = 32'h424BEB85;
    req_operation = 3'd0;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("add_Operand1", Operand1, 32'h46BFCA0A);
    chk("add_Operand2", Operand2, 32'h424BEB85);
    @(negedge CLK);
    chk("add_rsp_valid_early", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_rsp_result", rsp_result, 32'h46C03000);
    chk("add_rsp_operation", 32'(rsp_operation), 32'd0);
    @(posedge CLK);
    #1 drain(20);

    // burst of 8 with rsp_ready held high
    hs_cnt = 0;
    run_reqs(8, 0, 30, sent);
    drain(30);
    chk("burst_count", 32'(hs_cnt), 32'd8);
    chk("burst_span", 32'(hs_last - hs_first), 32'd7);

    // backpressure: 10 offered with rsp_ready low
    hs_cnt = 0;
    iss0 = m_iss_total;
    run_reqs(10, 1, 20, sent);
    @(negedge CLK);
    chk("bp_accepted", 32'(sent), 32'(REQ_DEPTH + RSP_DEPTH));
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    chk("bp_issues", 32'(m_iss_total - iss0), 32'(RSP_DEPTH));
    @(posedge CLK);
    #1 run_reqs(10 - sent, 0, 20, s2);
    drain(40);
    chk("bp_results", 32'(hs_cnt), 32'd10);

    // reset with two in flight and three queued
    run_reqs(8, 1, 30, sent);
    chk("rst_fill", 32'(sent), 32'd8);
    new_req();
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1 rsp_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge CLK);
      if (m_infl.size() == 2 && m_reqq.size() == 3) found = 1'b1;
    end
    chk("rst_setup", 32'(found), 32'd1);
    #2 RST = 1'b1;
    req_valid = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_Operand1", Operand1, 32'd0);
    chk("rst_mid_Operand2", Operand2, 32'd0);
    chk("rst_mid_Operation", 32'(Operation), 32'd0);
    chk("rst_mid_rsp_result", rsp_result, 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    rsp_ready = 1'b1;
    hs_cnt = 0;
    repeat (6) @(posedge CLK);
    #1 chk("rst_no_stale", 32'(hs_cnt), 32'd0);
    run_reqs(1, 0, 10, sent);
    drain(20);
    chk("rst_new_request", 32'(hs_cnt), 32'd1);

    // wrap-around and random traffic
    run_reqs(3 * REQ_DEPTH, 2, 600, sent);
    chk("wrap_sent", 32'(sent), 32'(3 * REQ_DEPTH));
    drain(60);
    run_reqs(60, 2, 2000, sent);
    chk("random_sent", 32'(sent), 32'd60);
    drain(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter REQ_DEPTH, default 4, meaning the request FIFO depth in entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RSP_DEPTH, default 4, meaning the result buffer depth in entries (power of two, 2..16).
REQ-003 The block SHALL have parameter FPU_LATENCY, default 2, meaning the number of CLK edges from Operand1/Operand2/Operation update to a valid FpuResult (1..8).
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  1  upstream request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_op1, req_op2  input  32 each  IEEE-754 single-precision operands.
REQ-009 req_operation  input  3  FPU operation code, passed through unmodified.
REQ-010 Operand1, Operand2  output  32 each  registered operands driven to the FPU.
REQ-011 Operation  output  3  registered operation code driven to the FPU.
REQ-012 FpuResult  input  32  FPU Result, valid FPU_LATENCY edges after issue.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  downstream accepts the result.
REQ-015 rsp_result  output  32  captured FPU result.
REQ-016 rsp_operation  output  3  operation code belonging to rsp_result.

Function
REQ-017 A request SHALL be accepted on an edge where req_valid and req_ready are both 1, and written into the request FIFO.
REQ-018 req_ready SHALL equal "request FIFO not full", with no combinational dependence on req_valid, the issue decision or rsp_ready.
REQ-019 Issue condition: request FIFO not empty AND (inflight + rsp_count) < RSP_DEPTH.
REQ-020 On an issue edge, the head entry SHALL be popped and loaded into Operand1/Operand2/Operation, and a valid token carrying the operation code SHALL enter a FPU_LATENCY-stage shift register.
REQ-021 Operand1/Operand2/Operation SHALL hold their last issued values on non-issue edges.
REQ-022 At most one issue per cycle and one accept per cycle SHALL occur; a push and a pop in the same cycle SHALL leave the FIFO count unchanged.
REQ-023 When a token exits the shift register, FpuResult and the token's operation code SHALL be written into the result buffer on that same edge.
REQ-024 The credit rule in REQ-019 SHALL guarantee that the result buffer never overflows; no FPU result SHALL be dropped.
REQ-025 inflight SHALL count the valid tokens in the shift register (0..FPU_LATENCY) and SHALL be updated by the issue and exit events occurring on the same edge.
REQ-026 rsp_valid SHALL equal "result buffer not empty"; rsp_result and rsp_operation SHALL show the oldest entry and SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-027 A result SHALL be popped on an edge where rsp_valid and rsp_ready are both 1; a simultaneous capture and pop SHALL leave rsp_count unchanged.
REQ-028 Results SHALL be returned in acceptance order.
REQ-029 Minimum latency from accept edge to rsp_valid=1 SHALL be FPU_LATENCY+1 edges, i.e. 3 edges with the default parameters.
REQ-030 Back-to-back throughput SHALL be one result per cycle when rsp_ready is held at 1.
REQ-031 FIFO pointers SHALL wrap modulo their depth; full is distinguished from empty by an explicit count or an extra pointer bit.

Reset
REQ-032 While RST=1 at an edge, the block SHALL empty both FIFOs, clear all tokens, and set inflight to 0.
REQ-033 While RST=1 at an edge, the block SHALL drive Operand1=0, Operand2=0, Operation=0, rsp_result=0, rsp_operation=0 and rsp_valid=0.
REQ-034 req_ready SHALL be 0 during reset and SHALL be 1 on the first cycle after RST deasserts.
REQ-035 A reset asserted while operations are in flight SHALL discard them: results arriving later are not captured, and no rsp_valid pulse is produced.
REQ-036 During reset, accepts and issues SHALL be ignored.

Verification
REQ-037 Single add: request op1=0x46BFCA0A, op2=0x424BEB85, op=0 with a behavioural FPU (L=2) -> Operand1/Operand2 load 1 edge after accept; rsp_valid=1 after 3 edges with rsp_result=0x46C03000 and rsp_operation=0.
REQ-038 Burst: 8 back-to-back requests with rsp_ready=1 -> 8 results in order, one per cycle, with no gaps after the first.
REQ-039 Backpressure: rsp_ready=0 while 10 requests are offered -> exactly RSP_DEPTH issues occur, the request FIFO fills, req_ready=0, and Operand1 holds its value; after rsp_ready=1, all 10 results arrive in order with none lost.
REQ-040 Simultaneous events: full request FIFO with push and pop on the same edge, and full result buffer with capture and pop on the same edge -> counts remain unchanged and data is correct.
REQ-041 Reset mid-operation: assert RST with 2 operations in flight and 3 entries queued -> all outputs go to their reset values, no stale rsp_valid afterwards, and a new request completes normally.
REQ-042 Wrap-around: 3*REQ_DEPTH sequential requests with random rsp_ready -> the scoreboard matches every result in order.
